// File: rtl/syn_fifo_flex_if.sv
// syn_fifo_flex_if
// Handshake and status bundle for syn_fifo_flex.
//   master : producer/consumer side (drives wr_en_i, wdata_i, rd_en_i)
//   slave  : FIFO side (drives read data, valid strobe, flags, count and
//            the overflow/underflow pulses)
// CNT_WIDTH must match the FIFO's derived $clog2(DEPTH+1).
interface syn_fifo_flex_if #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 5
);
  logic                 wr_en_i;
  logic [WIDTH-1:0]     wdata_i;
  logic                 rd_en_i;
  logic [WIDTH-1:0]     rdata_o;
  logic                 rdata_valid_o;
  logic                 full_o;
  logic                 almost_full_o;
  logic                 empty_o;
  logic                 almost_empty_o;
  logic [CNT_WIDTH-1:0] count_o;
  logic                 overflow_o;
  logic                 underflow_o;

  modport master (
    output wr_en_i, wdata_i, rd_en_i,
    input  rdata_o, rdata_valid_o, full_o, almost_full_o, empty_o,
           almost_empty_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  wr_en_i, wdata_i, rd_en_i,
    output rdata_o, rdata_valid_o, full_o, almost_full_o, empty_o,
           almost_empty_o, count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/syn_fifo_flex.sv
// syn_fifo_flex
// Single-clock FIFO with standard (registered) or first-word-fall-through
// read mode, programmable almost-full/almost-empty thresholds, occupancy
// count, read-data-valid strobe and overflow/underflow pulses.
// Ports:
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset
//   bus    : syn_fifo_flex_if.slave (write/read requests, data, flags, count)
module syn_fifo_flex #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int FWFT      = 0,
  parameter int AF_LEVEL  = DEPTH - 2,
  parameter int AE_LEVEL  = 2,
  parameter int CNT_WIDTH = $clog2(DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  syn_fifo_flex_if.slave  bus
);

  localparam int PNT = $clog2(DEPTH);

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PNT-1:0]       wr_ptr_q;
  logic [PNT-1:0]       rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_next;
  logic                 full_q;
  logic                 almost_full_q;
  logic                 empty_q;
  logic                 almost_empty_q;
  logic                 overflow_q;
  logic                 underflow_q;
  logic                 wr_accept;
  logic                 rd_accept;

  // Acceptance looks only at the registered flags, so there is no
  // combinational path from the requests to any flag or the count.
  assign wr_accept = bus.wr_en_i && !full_q;
  assign rd_accept = bus.rd_en_i && !empty_q;

  always_comb begin
    count_next = count_q;
    if (wr_accept && !rd_accept) begin
      count_next = count_q + CNT_WIDTH'(1);
    end else if (rd_accept && !wr_accept) begin
      count_next = count_q - CNT_WIDTH'(1);
    end
  end

  // Storage is deliberately not reset; pointers decide what is valid.
  always_ff @(posedge clk_i) begin
    if (wr_accept) begin
      mem[wr_ptr_q] <= bus.wdata_i;
    end
  end

  // Flags are computed from count_next so they move on the same edge as count.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (wr_accept) begin
        wr_ptr_q <= wr_ptr_q + PNT'(1);
      end
      if (rd_accept) begin
        rd_ptr_q <= rd_ptr_q + PNT'(1);
      end
      count_q        <= count_next;
      full_q         <= (count_next == CNT_WIDTH'(DEPTH));
      almost_full_q  <= (count_next >= CNT_WIDTH'(AF_LEVEL));
      empty_q        <= (count_next == '0);
      almost_empty_q <= (count_next <= CNT_WIDTH'(AE_LEVEL));
      overflow_q     <= bus.wr_en_i && full_q;
      underflow_q    <= bus.rd_en_i && empty_q;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is exposed directly; it is meaningless while empty.
      assign bus.rdata_o       = mem[rd_ptr_q];
      assign bus.rdata_valid_o = !empty_q;
    end else begin : g_std
      logic [WIDTH-1:0] rdata_q;
      logic             rdata_valid_q;

      // Registered read: data lands one cycle after the accepted read and
      // is held until the next accepted read.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          rdata_q       <= '0;
          rdata_valid_q <= 1'b0;
        end else begin
          rdata_valid_q <= rd_accept;
          if (rd_accept) begin
            rdata_q <= mem[rd_ptr_q];
          end
        end
      end

      assign bus.rdata_o       = rdata_q;
      assign bus.rdata_valid_o = rdata_valid_q;
    end
  endgenerate

  assign bus.count_o        = count_q;
  assign bus.full_o         = full_q;
  assign bus.almost_full_o  = almost_full_q;
  assign bus.empty_o        = empty_q;
  assign bus.almost_empty_o = almost_empty_q;
  assign bus.overflow_o     = overflow_q;
  assign bus.underflow_o    = underflow_q;

endmodule

// File: tb/tb_syn_fifo_flex.sv
// tb_syn_fifo_flex
// Self-checking bench for syn_fifo_flex: a standard-mode instance driven from
// a vector table plus hand-written sequences, and a FWFT instance.
module tb_syn_fifo_flex;

  localparam int WIDTH     = 8;
  localparam int DEPTH     = 16;
  localparam int CNT_WIDTH = $clog2(DEPTH + 1);

  logic clk_i;
  logic rst_i;

  int checks;
  int failures;

  syn_fifo_flex_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) sbus ();
  syn_fifo_flex_if #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) fbus ();

  syn_fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(0)) dut_std (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (sbus)
  );

  syn_fifo_flex #(.WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(1)) dut_fwft (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (fbus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       wr;
    logic [7:0] wdata;
    logic       rd;
    int         cnt;
    logic       empty;
    logic       full;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
    logic       valid;
    logic [7:0] rdata;
  } vec_t;

  vec_t vecs[17];
  logic [7:0] model_q[$];
  logic [7:0] exp_word;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Drives one cycle on the standard instance, returns #1 after the edge.
  task automatic applyStimulus(input logic wr, input logic [7:0] d, input logic rd);
    sbus.wr_en_i = wr;
    sbus.wdata_i = d;
    sbus.rd_en_i = rd;
    @(posedge clk_i);
    #1;
    sbus.wr_en_i = 1'b0;
    sbus.rd_en_i = 1'b0;
  endtask

  task automatic applyStimulusFwft(input logic wr, input logic [7:0] d, input logic rd);
    fbus.wr_en_i = wr;
    fbus.wdata_i = d;
    fbus.rd_en_i = rd;
    @(posedge clk_i);
    #1;
    fbus.wr_en_i = 1'b0;
    fbus.rd_en_i = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    sbus.wr_en_i = 1'b0; sbus.rd_en_i = 1'b0; sbus.wdata_i = '0;
    fbus.wr_en_i = 1'b0; fbus.rd_en_i = 1'b0; fbus.wdata_i = '0;

    //          wr    wdata  rd   cnt e  f  af ae ovf unf v  rdata
    vecs[0]  = '{1'b1, 8'd100, 1'b0, 1, 0, 0, 0, 1, 0, 0, 0, 8'd0};
    vecs[1]  = '{1'b1, 8'd101, 1'b0, 2, 0, 0, 0, 1, 0, 0, 0, 8'd0};
    vecs[2]  = '{1'b1, 8'd102, 1'b0, 3, 0, 0, 0, 0, 0, 0, 0, 8'd0};
    vecs[3]  = '{1'b1, 8'd103, 1'b0, 4, 0, 0, 0, 0, 0, 0, 0, 8'd0};
    vecs[4]  = '{1'b1, 8'd104, 1'b0, 5, 0, 0, 0, 0, 0, 0, 0, 8'd0};
    vecs[5]  = '{1'b0, 8'd0,   1'b1, 4, 0, 0, 0, 0, 0, 0, 1, 8'd100};
    vecs[6]  = '{1'b0, 8'd0,   1'b1, 3, 0, 0, 0, 0, 0, 0, 1, 8'd101};
    vecs[7]  = '{1'b0, 8'd0,   1'b1, 2, 0, 0, 0, 1, 0, 0, 1, 8'd102};
    vecs[8]  = '{1'b0, 8'd0,   1'b1, 1, 0, 0, 0, 1, 0, 0, 1, 8'd103};
    vecs[9]  = '{1'b0, 8'd0,   1'b1, 0, 1, 0, 0, 1, 0, 0, 1, 8'd104};
    vecs[10] = '{1'b0, 8'd0,   1'b0, 0, 1, 0, 0, 1, 0, 0, 0, 8'd104};
    vecs[11] = '{1'b0, 8'd0,   1'b1, 0, 1, 0, 0, 1, 0, 1, 0, 8'd104};
    vecs[12] = '{1'b0, 8'd0,   1'b1, 0, 1, 0, 0, 1, 0, 1, 0, 8'd104};
    vecs[13] = '{1'b0, 8'd0,   1'b0, 0, 1, 0, 0, 1, 0, 0, 0, 8'd104};
    vecs[14] = '{1'b1, 8'h55,  1'b1, 1, 0, 0, 0, 1, 0, 1, 0, 8'd104};
    vecs[15] = '{1'b0, 8'd0,   1'b1, 0, 1, 0, 0, 1, 0, 0, 1, 8'h55};
    vecs[16] = '{1'b0, 8'd0,   1'b0, 0, 1, 0, 0, 1, 0, 0, 0, 8'h55};

    // Reset for four cycles and check the reset state while it is held.
    rst_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    checkOutput("rst_count", 32'(sbus.count_o), 0);
    checkOutput("rst_empty", 32'(sbus.empty_o), 1);
    checkOutput("rst_ae", 32'(sbus.almost_empty_o), 1);
    checkOutput("rst_full", 32'(sbus.full_o), 0);
    checkOutput("rst_af", 32'(sbus.almost_full_o), 0);
    checkOutput("rst_valid", 32'(sbus.rdata_valid_o), 0);
    checkOutput("rst_rdata", 32'(sbus.rdata_o), 0);
    checkOutput("rst_fwft_valid", 32'(fbus.rdata_valid_o), 0);
    rst_i = 1'b0;

    $display("[TB] vector table");
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].wr, vecs[i].wdata, vecs[i].rd);
      checkOutput($sformatf("v%0d_count", i), 32'(sbus.count_o), 32'(vecs[i].cnt));
      checkOutput($sformatf("v%0d_empty", i), 32'(sbus.empty_o), 32'(vecs[i].empty));
      checkOutput($sformatf("v%0d_full", i), 32'(sbus.full_o), 32'(vecs[i].full));
      checkOutput($sformatf("v%0d_af", i), 32'(sbus.almost_full_o), 32'(vecs[i].af));
      checkOutput($sformatf("v%0d_ae", i), 32'(sbus.almost_empty_o), 32'(vecs[i].ae));
      checkOutput($sformatf("v%0d_ovf", i), 32'(sbus.overflow_o), 32'(vecs[i].ovf));
      checkOutput($sformatf("v%0d_unf", i), 32'(sbus.underflow_o), 32'(vecs[i].unf));
      checkOutput($sformatf("v%0d_valid", i), 32'(sbus.rdata_valid_o), 32'(vecs[i].valid));
      checkOutput($sformatf("v%0d_rdata", i), 32'(sbus.rdata_o), 32'(vecs[i].rdata));
    end

    $display("[TB] fill, overflow, simultaneous on full, drain with underflow");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 8'(200 + i), 1'b0);
      checkOutput($sformatf("fill%0d_count", i), 32'(sbus.count_o), 32'(i + 1));
      checkOutput($sformatf("fill%0d_af", i), 32'(sbus.almost_full_o), 32'((i + 1) >= 14));
      checkOutput($sformatf("fill%0d_full", i), 32'(sbus.full_o), 32'((i + 1) == 16));
      checkOutput($sformatf("fill%0d_ae", i), 32'(sbus.almost_empty_o), 32'((i + 1) <= 2));
    end
    applyStimulus(1'b1, 8'hEE, 1'b0);
    checkOutput("ovf_pulse", 32'(sbus.overflow_o), 1);
    checkOutput("ovf_count", 32'(sbus.count_o), 16);
    checkOutput("ovf_full", 32'(sbus.full_o), 1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkOutput("ovf_clear", 32'(sbus.overflow_o), 0);
    applyStimulus(1'b1, 8'hDD, 1'b1);
    checkOutput("both_full_ovf", 32'(sbus.overflow_o), 1);
    checkOutput("both_full_count", 32'(sbus.count_o), 15);
    checkOutput("both_full_rdata", 32'(sbus.rdata_o), 200);
    checkOutput("both_full_valid", 32'(sbus.rdata_valid_o), 1);
    for (int i = 1; i < DEPTH; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      checkOutput($sformatf("drain%0d_rdata", i), 32'(sbus.rdata_o), 32'(200 + i));
      checkOutput($sformatf("drain%0d_count", i), 32'(sbus.count_o), 32'(15 - i));
      checkOutput($sformatf("drain%0d_ae", i), 32'(sbus.almost_empty_o), 32'((15 - i) <= 2));
      checkOutput($sformatf("drain%0d_ovf", i), 32'(sbus.overflow_o), 0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("drain_unf", 32'(sbus.underflow_o), 1);
    checkOutput("drain_unf_count", 32'(sbus.count_o), 0);
    checkOutput("drain_unf_valid", 32'(sbus.rdata_valid_o), 0);
    checkOutput("drain_unf_rdata", 32'(sbus.rdata_o), 215);

    $display("[TB] half-full streaming with pointer wrap");
    model_q = {};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0);
      model_q.push_back(8'(8'h10 + i));
    end
    checkOutput("half_count", 32'(sbus.count_o), 8);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'(8'h40 + i), 1'b1);
      exp_word = model_q.pop_front();
      model_q.push_back(8'(8'h40 + i));
      checkOutput($sformatf("stream%0d_rdata", i), 32'(sbus.rdata_o), 32'(exp_word));
      checkOutput($sformatf("stream%0d_count", i), 32'(sbus.count_o), 8);
    end
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b1);
      exp_word = model_q.pop_front();
      checkOutput($sformatf("tail%0d_rdata", i), 32'(sbus.rdata_o), 32'(exp_word));
    end
    checkOutput("tail_empty", 32'(sbus.empty_o), 1);

    $display("[TB] asynchronous reset mid-operation");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'(8'h70 + i), 1'b0);
    end
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("pre_rst_rdata", 32'(sbus.rdata_o), 32'h70);
    #2;
    rst_i = 1'b1;
    #1;
    checkOutput("async_rst_count", 32'(sbus.count_o), 0);
    checkOutput("async_rst_empty", 32'(sbus.empty_o), 1);
    checkOutput("async_rst_ae", 32'(sbus.almost_empty_o), 1);
    checkOutput("async_rst_valid", 32'(sbus.rdata_valid_o), 0);
    checkOutput("async_rst_rdata", 32'(sbus.rdata_o), 0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    applyStimulus(1'b1, 8'h3C, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkOutput("post_rst_rdata", 32'(sbus.rdata_o), 32'h3C);
    checkOutput("post_rst_valid", 32'(sbus.rdata_valid_o), 1);
    checkOutput("post_rst_count", 32'(sbus.count_o), 0);

    $display("[TB] first-word-fall-through instance");
    checkOutput("fwft_idle_valid", 32'(fbus.rdata_valid_o), 0);
    applyStimulusFwft(1'b1, 8'hA5, 1'b0);
    checkOutput("fwft_head", 32'(fbus.rdata_o), 32'hA5);
    checkOutput("fwft_valid", 32'(fbus.rdata_valid_o), 1);
    checkOutput("fwft_count", 32'(fbus.count_o), 1);
    applyStimulusFwft(1'b0, 8'h00, 1'b1);
    checkOutput("fwft_pop_valid", 32'(fbus.rdata_valid_o), 0);
    checkOutput("fwft_pop_empty", 32'(fbus.empty_o), 1);
    applyStimulusFwft(1'b1, 8'h11, 1'b0);
    applyStimulusFwft(1'b1, 8'h22, 1'b0);
    checkOutput("fwft_head2", 32'(fbus.rdata_o), 32'h11);
    applyStimulusFwft(1'b0, 8'h00, 1'b1);
    checkOutput("fwft_next", 32'(fbus.rdata_o), 32'h22);
    checkOutput("fwft_next_valid", 32'(fbus.rdata_valid_o), 1);
    applyStimulusFwft(1'b0, 8'h00, 1'b1);
    applyStimulusFwft(1'b0, 8'h00, 1'b1);
    checkOutput("fwft_unf", 32'(fbus.underflow_o), 1);
    checkOutput("fwft_unf_count", 32'(fbus.count_o), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/syn_fifo_flex.md
Name: syn_fifo_flex

Overview:
Parametrised single-clock FIFO, the next generation of the team's syn_fifo.
- Adds a selectable standard or first-word-fall-through (FWFT) read mode, programmable almost-full/almost-empty thresholds, an occupancy count and a read-data-valid strobe.
- Keeps the full/empty and overflow/underflow semantics the existing benches expect.
- Used as the general buffering primitive between producer and consumer logic in one clock domain.

Parameters:
WIDTH, 8, data word width in bits (>=1)
DEPTH, 16, number of entries; power of two, >=4
FWFT, 0, read mode: 0 = standard registered read, 1 = first-word-fall-through
AF_LEVEL, DEPTH-2, almost_full_o asserts when count >= AF_LEVEL (1..DEPTH)
AE_LEVEL, 2, almost_empty_o asserts when count <= AE_LEVEL (0..DEPTH-1)
CNT_WIDTH, $clog2(DEPTH+1), occupancy count width (derived; do not override)

Ports:
clk_i  input  1  clock, rising edge
rst_i  input  1  asynchronous active-high reset
wr_en_i  input  1  write request
wdata_i  input  WIDTH  write data
rd_en_i  input  1  read request (FWFT: pop/acknowledge of current head)
rdata_o  output  WIDTH  read data
rdata_valid_o  output  1  rdata_o holds a valid word
full_o  output  1  count == DEPTH
almost_full_o  output  1  count >= AF_LEVEL
empty_o  output  1  count == 0
almost_empty_o  output  1  count <= AE_LEVEL
count_o  output  CNT_WIDTH  current occupancy 0..DEPTH
overflow_o  output  1  one-cycle pulse: write rejected
underflow_o  output  1  one-cycle pulse: read rejected

Behaviour:
- Reset (async, immediate, also mid-operation):
  - Clears wr/rd pointers and count_o to 0; empty_o=1, almost_empty_o=1.
  - Clears full_o, almost_full_o, overflow_o, underflow_o and rdata_valid_o to 0; standard-mode rdata_o to 0.
  - Memory array not cleared; all stored words discarded.
- Accept rules use the registered flags at the clock edge:
  - write accepted iff wr_en_i && !full_o;
  - read accepted iff rd_en_i && !empty_o.
- Accepted write: mem[wr_ptr] <= wdata_i; wr_ptr increments modulo DEPTH (natural wrap, PNT bits = $clog2(DEPTH)).
- Accepted read: rd_ptr increments modulo DEPTH.
- count_o: +1 on write-only, -1 on read-only, unchanged when both are accepted or neither.
- All flags are registered and derived from the next count, so they update on the same edge as count_o.
- Simultaneous wr+rd while full: read accepted, write rejected, overflow_o pulses, count DEPTH-1.
- Simultaneous wr+rd while empty: write accepted, read rejected, underflow_o pulses, count 1.
- overflow_o/underflow_o: high for exactly the one cycle after the rejecting edge; back-to-back rejections keep them high. Pointers and count are unaffected.
- Standard mode (FWFT=0):
  - On an accepted read, rdata_o <= mem[rd_ptr] at that edge, so data is visible one cycle after rd_en_i is sampled.
  - rdata_valid_o pulses high for that one cycle.
  - rdata_o holds its last value otherwise.
- FWFT mode (FWFT=1):
  - rdata_o = mem[rd_ptr] combinationally; rdata_valid_o = !empty_o.
  - The head word is visible the cycle after the write that made the FIFO non-empty.
  - rd_en_i pops the head; the next word appears after the edge.
  - When empty, rdata_o is don't-care.
- No combinational path from wr_en_i/rd_en_i to any flag or count.

Test Plan:
- Reset 4 cycles; write 5 words (100..104), then 5 reads, FWFT=0 -> rdata_o 100..104 each one cycle after the read edge, rdata_valid_o pulses 5 times; count 5->0; empty_o=1 at end.
- Write 16 words -> almost_full_o rises when count reaches 14, full_o when count reaches 16; 17th write -> overflow_o pulses for 1 cycle, count stays 16, contents unchanged on readback.
- From empty, read 1 -> underflow_o pulses for 1 cycle, count 0. Write 16 then read 17 -> last read underflows; almost_empty_o asserts when count reaches 2.
- Full FIFO, wr_en_i and rd_en_i together for 1 cycle -> overflow_o pulse, count 15. Half-full (8) with both held 20 cycles -> count stays 8, pointers wrap past 15, data order preserved.
- FWFT=1: write 0xA5 -> next cycle rdata_o=0xA5, rdata_valid_o=1 without rd_en_i; pop -> rdata_valid_o=0, empty_o=1.
- Write 6 words, assert rst_i mid-cycle -> outputs clear immediately (no clock edge needed); after release a write/read of 0x3C returns 0x3C, not stale data.
